misaligned_lsu: RTL and testbench
=================================

// Module: misaligned_lsu
// PURPOSE
//  Load/store sequencer between the MEM-stage control and data_memory. Takes one load/store request
//  per handshake. Aligned accesses issue as a single native memory op.
//  Misaligned halfword/word accesses split into little-endian byte ops, one per cycle.
//  Load bytes are assembled and sign/zero extended before the response is returned.
// PARAMETERS
//  SIZE          32     data/address width
//  BASE_ADDRESS  32'h0  forwarded unchanged; address math is absolute, wraps mod 2^SIZE
// PORTS
//  clk              in   1     single clock, rising edge
//  reset_n          in   1     asynchronous, active-low reset
//  req_valid        in   1     request present
//  req_ready        out  1     request accepted when req_valid & req_ready
//  req_write        in   1     1=store, 0=load
//  req_address      in   SIZE  byte address
//  req_write_data   in   SIZE  store data, LSB-aligned
//  req_data_size    in   2     00 byte, 01 half, 10 word, 11 illegal
//  req_extension    in   1     1=zero-extend, 0=sign-extend (loads)
//  resp_valid       out  1     response present; held until resp_ready
//  resp_ready       in   1     consumer accepts response
//  resp_read_data   out  SIZE  extended load data (0 for stores)
//  resp_error       out  1     illegal size (or misaligned when trap build)
//  mem_address      out  SIZE  to data_memory address
//  mem_write_data   out  SIZE  to data_memory write_data
//  mem_data_size    out  2     to data_memory data_size
//  mem_extension    out  1     to data_memory extension_type
//  mem_write_enable out  1     to data_memory write_enable
//  mem_read_data    in   SIZE  from data_memory read_data (combinational)
// BEHAVIOUR
//  Reset: state=IDLE. req_ready=1. resp_valid=0, resp_error=0, resp_read_data=0. All mem_* outputs=0.
//  FSM: IDLE -> ACCESS on accept (req fields registered); ACCESS -> RESP after last op; RESP -> IDLE on resp_ready.
//  req_ready=1 only in IDLE. No new request while ACCESS/RESP. Back-to-back: IDLE next cycle after RESP handshake.
//  Illegal size 11: IDLE -> RESP directly, resp_error=1, zero memory ops, no write.
//  Aligned (byte; half with addr[0]=0; word with addr[1:0]=00): one ACCESS cycle, native size, mem_extension=1.
//    Load data captured from mem_read_data at that edge. resp_valid asserts 2 cycles after accept.
//  Misaligned half: 2 byte ops. Misaligned word: 4 byte ops.
//    Op k uses mem_address=addr+k (wraps 32'hFFFFFFFF->0), mem_data_size=00, mem_extension=1.
//    Store op k: mem_write_data[7:0]=write_data[8k+7:8k], mem_write_enable=1 that cycle only.
//    Load op k: byte k captured into assembly reg[8k+7:8k].
//  Extension applied once in RESP from assembled bytes: byte->bit7, half->bit15, word none; req_extension=1 zeroes.
//  Stores: resp_read_data=0. mem_write_enable never asserted outside ACCESS or for loads.
//  resp_valid & !resp_ready: all resp_* outputs held stable.
//  Reset mid-ACCESS: immediate return to IDLE. Remaining byte ops are not issued; already-written bytes stay written.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: misaligned half/word do no memory op.
//    IDLE -> RESP with resp_error=1, resp_read_data=0, latency 1 cycle.
//  Not defined: misaligned accesses split as above. resp_error is set only for size 11.
// STRUCTURE
//  Package riscv_mem_pkg holds size encodings (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL), lsu_state_t enum and
//    the extension-type polarity constant.
//  Sub-module load_extender: combinational; assembled data, size and extension in; extended word out.
//    Reused by the pipelined core.
// TESTING
//  1 aligned word store 0xDEADBEEF @0x10, then load -> 1 mem op each, resp_read_data=0xDEADBEEF, resp 2 cycles after accept.
//  2 misaligned word store 0x11223344 @0x21 -> byte writes 44,33,22,11 @0x21..0x24 on 4 consecutive cycles;
//    then word load @0x21 returns 0x11223344.
//  3 misaligned half load @0x33 with bytes 0x80,0xFF, req_extension=0 -> 0xFFFFFF80;
//    req_extension=1 -> 0x0000FF80.
//  4 word store @0xFFFFFFFE -> byte ops at 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (address wrap).
//  5 size 11 -> resp_error=1, mem_write_enable never high. resp_ready low for 3 cycles -> resp_* held stable.
//  6 reset_n low in 2nd byte op of misaligned store -> IDLE, req_ready=1, no 3rd write.
//    Rerun cases 2-4 with MISALIGN_TRAP_EN: resp_error=1, zero memory ops.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared memory-access encodings: size codes, LSU state enum, extension polarity.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package riscv_mem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // data_memory extension_type: 1 zero-extends, 0 sign-extends.
    localparam logic EXT_ZERO = 1'b1;
    localparam logic EXT_SIGN = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    // Natural alignment check for byte/half/word. Illegal size reports aligned;
    // it is rejected separately.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b1;
        if (size == SZ_HALF) ok = (addr_lo[0] == 1'b0);
        if (size == SZ_WORD) ok = (addr_lo == 2'b00);
        return ok;
    endfunction

endpackage

// File: rtl/load_extender.sv
// Sign/zero extension of assembled load data to a full word, shared with the pipelined core.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of its inputs).
// Ports: data_i assembled LSB-aligned bytes, size_i access size, ext_i 1=zero/0=sign,
//        ext_data_o extended word.
module load_extender
    import riscv_mem_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] data_i,
    input  logic [1:0]      size_i,
    input  logic            ext_i,
    output logic [SIZE-1:0] ext_data_o
);

    logic fill;

    always_comb begin
        fill       = 1'b0;
        ext_data_o = data_i;
        case (size_i)
            SZ_BYTE: begin
                fill       = (ext_i == EXT_ZERO) ? 1'b0 : data_i[7];
                ext_data_o = {{(SIZE-8){fill}}, data_i[7:0]};
            end
            SZ_HALF: begin
                fill       = (ext_i == EXT_ZERO) ? 1'b0 : data_i[15];
                ext_data_o = {{(SIZE-16){fill}}, data_i[15:0]};
            end
            default: ext_data_o = data_i;
        endcase
    end

endmodule

// File: rtl/misaligned_lsu.sv
// Load/store sequencer: aligned ops go out native, misaligned half/word split into byte ops.
// Latency: aligned 2 cycles accept->resp, misaligned half 3, word 5, illegal/trapped 1.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
// Ports: req_* request handshake, resp_* response handshake, mem_* data_memory interface.
// Build option: MISALIGN_TRAP_EN turns misaligned half/word into an error response with no memory op.
module misaligned_lsu
    import riscv_mem_pkg::*;
#(
    parameter int              SIZE         = 32,
    parameter logic [SIZE-1:0] BASE_ADDRESS = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [SIZE-1:0] req_address,
    input  logic [SIZE-1:0] req_write_data,
    input  logic [1:0]      req_data_size,
    input  logic            req_extension,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [SIZE-1:0] resp_read_data,
    output logic            resp_error,
    output logic [SIZE-1:0] mem_address,
    output logic [SIZE-1:0] mem_write_data,
    output logic [1:0]      mem_data_size,
    output logic            mem_extension,
    output logic            mem_write_enable,
    input  logic [SIZE-1:0] mem_read_data
);

    // BASE_ADDRESS belongs to the memory map only; all address math here is absolute.
    if (BASE_ADDRESS != '0) begin : g_nonzero_base
    end

    lsu_state_t      state_q, state_d;
    logic            write_q, write_d;
    logic [SIZE-1:0] addr_q, addr_d;
    logic [SIZE-1:0] wdata_q, wdata_d;
    logic [1:0]      size_q, size_d;
    logic            ext_q, ext_d;
    logic            err_q, err_d;
    logic            aligned_q, aligned_d;
    logic [1:0]      op_q, op_d;
    logic [SIZE-1:0] asm_q, asm_d;

    logic [SIZE-1:0] wdata_shift;
    logic [1:0]      last_op;
    logic [SIZE-1:0] ext_data;

    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        size_d           = size_q;
        ext_d            = ext_q;
        err_d            = err_q;
        aligned_d        = aligned_q;
        op_d             = op_q;
        asm_d            = asm_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_data_size    = SZ_BYTE;
        mem_extension    = 1'b0;
        mem_write_enable = 1'b0;
        wdata_shift      = wdata_q >> {op_q, 3'b000};
        last_op          = (size_q == SZ_HALF) ? 2'd1 : 2'd3;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d   = req_write;
                    addr_d    = req_address;
                    wdata_d   = req_write_data;
                    size_d    = req_data_size;
                    ext_d     = req_extension;
                    aligned_d = is_aligned(req_data_size, req_address[1:0]);
                    op_d      = 2'd0;
                    asm_d     = '0;   // unused upper bytes of a split half must read as zero
                    err_d     = 1'b0;
                    if (req_data_size == SZ_ILLEGAL) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
`ifdef MISALIGN_TRAP_EN
                    else if (!is_aligned(req_data_size, req_address[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
`endif
                    else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                // Memory always zero-extends; the requested extension is applied once in RESP.
                mem_extension    = EXT_ZERO;
                mem_write_enable = write_q;
                if (aligned_q) begin
                    mem_address    = addr_q;
                    mem_data_size  = size_q;
                    mem_write_data = wdata_q;
                    asm_d          = mem_read_data;
                    state_d        = ST_RESP;
                end else begin
                    // Little-endian byte k of the request goes to addr+k (wraps naturally).
                    mem_address                 = addr_q + {{(SIZE-2){1'b0}}, op_q};
                    mem_data_size               = SZ_BYTE;
                    mem_write_data              = {{(SIZE-8){1'b0}}, wdata_shift[7:0]};
                    asm_d[{op_q, 3'b000} +: 8]  = mem_read_data[7:0];
                    if (op_q == last_op) begin
                        state_d = ST_RESP;
                    end else begin
                        op_d = op_q + 2'd1;
                    end
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    load_extender #(.SIZE(SIZE)) u_load_extender (
        .data_i     (asm_q),
        .size_i     (size_q),
        .ext_i      (ext_q),
        .ext_data_o (ext_data)
    );

    // Response fields come straight from held registers, so they stay stable under backpressure.
    assign resp_error     = (state_q == ST_RESP) && err_q;
    assign resp_read_data = ((state_q == ST_RESP) && !write_q && !err_q) ? ext_data : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= SZ_BYTE;
            ext_q     <= 1'b0;
            err_q     <= 1'b0;
            aligned_q <= 1'b0;
            op_q      <= 2'd0;
            asm_q     <= '0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            ext_q     <= ext_d;
            err_q     <= err_d;
            aligned_q <= aligned_d;
            op_q      <= op_d;
            asm_q     <= asm_d;
        end
    end

endmodule

// File: tb/tb_misaligned_lsu.sv
// Directed bench for misaligned_lsu with a byte-array memory model behind the mem_* port.
// Latency: n/a.
// Backpressure: exercises a held response with resp_ready low.
module tb_misaligned_lsu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_address = '0;
    logic [31:0] req_write_data = '0;
    logic [1:0]  req_data_size = 2'b00;
    logic        req_extension = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_read_data;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [1:0]  mem_data_size;
    logic        mem_extension;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    misaligned_lsu dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_address      (req_address),
        .req_write_data   (req_write_data),
        .req_data_size    (req_data_size),
        .req_extension    (req_extension),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_read_data   (resp_read_data),
        .resp_error       (resp_error),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_data_size    (mem_data_size),
        .mem_extension    (mem_extension),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    // 256-byte memory indexed by address[7:0]; the test addresses do not alias.
    logic [7:0]  mem [256];
    int          cyc = 0;
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic [1:0]  log_size [$];
    int          log_cyc  [$];

    always_comb begin
        logic [7:0] a;
        logic [7:0] b0, b1, b2, b3;
        a  = mem_address[7:0];
        b0 = mem[a];
        b1 = mem[8'(a + 8'd1)];
        b2 = mem[8'(a + 8'd2)];
        b3 = mem[8'(a + 8'd3)];
        case (mem_data_size)
            2'b00:   mem_read_data = mem_extension ? {24'h0, b0} : {{24{b0[7]}}, b0};
            2'b01:   mem_read_data = mem_extension ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: mem_read_data = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_write_enable) begin
            mem[mem_address[7:0]] = mem_write_data[7:0];
            if (mem_data_size != 2'b00) mem[8'(mem_address[7:0] + 8'd1)] = mem_write_data[15:8];
            if (mem_data_size == 2'b10) begin
                mem[8'(mem_address[7:0] + 8'd2)] = mem_write_data[23:16];
                mem[8'(mem_address[7:0] + 8'd3)] = mem_write_data[31:24];
            end
            log_addr.push_back(mem_address);
            log_data.push_back(mem_write_data);
            log_size.push_back(mem_data_size);
            log_cyc.push_back(cyc);
        end
    end

    int          vecs = 0;
    int          errs = 0;
    logic [31:0] r_data;
    logic        r_err;
    int          r_lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_size.delete();
        log_cyc.delete();
    endtask

    // Issues one request and waits (bounded) for resp_valid. r_lat counts cycles from the
    // handshake cycle (cycle 0) to the first cycle with resp_valid high.
    task automatic start_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] sz, input logic ext, input logic rdy);
        @(negedge clk);
        req_write      = wr;
        req_address    = a;
        req_write_data = wd;
        req_data_size  = sz;
        req_extension  = ext;
        resp_ready     = rdy;
        req_valid      = 1'b1;
        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        r_lat = 1;
        while (!resp_valid && r_lat < 20) begin
            @(posedge clk);
            #1;
            r_lat++;
        end
        chk("resp_valid_seen", {31'h0, resp_valid}, 32'h1);
        r_data = resp_read_data;
        r_err  = resp_error;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic ext);
        start_req(wr, a, wd, sz, ext, 1'b1);
        finish_resp();
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_error", {31'h0, resp_error}, 32'h0);
        chk("rst_resp_data", resp_read_data, 32'h0);
        chk("rst_mem_we", {31'h0, mem_write_enable}, 32'h0);
        chk("rst_mem_addr", mem_address, 32'h0);
        chk("rst_mem_wdata", mem_write_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: aligned word store + load
        clear_log();
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
        chk("t1_st_lat", r_lat, 2);
        chk("t1_st_err", {31'h0, r_err}, 32'h0);
        chk("t1_st_data", r_data, 32'h0);
        chk("t1_st_nops", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            chk("t1_st_addr", log_addr[0], 32'h10);
            chk("t1_st_wdata", log_data[0], 32'hDEADBEEF);
            chk("t1_st_size", {30'h0, log_size[0]}, 32'h2);
        end
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
        chk("t1_ld_lat", r_lat, 2);
        chk("t1_ld_data", r_data, 32'hDEADBEEF);
        chk("t1_ld_nops", log_addr.size(), 1);

        // 2: misaligned word store + load
        clear_log();
        do_req(1'b1, 32'h21, 32'h11223344, 2'b10, 1'b0);
`ifdef MISALIGN_TRAP_EN
        chk("t2_st_err", {31'h0, r_err}, 32'h1);
        chk("t2_st_lat", r_lat, 1);
        chk("t2_st_nops", log_addr.size(), 0);
        do_req(1'b0, 32'h21, 32'h0, 2'b10, 1'b1);
        chk("t2_ld_err", {31'h0, r_err}, 32'h1);
        chk("t2_ld_lat", r_lat, 1);
        chk("t2_ld_data", r_data, 32'h0);
`else
        chk("t2_st_err", {31'h0, r_err}, 32'h0);
        chk("t2_st_lat", r_lat, 5);
        chk("t2_st_nops", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("t2_st_addr", log_addr[k], 32'h21 + 32'(k));
                chk("t2_st_byte", log_data[k], 32'h44 - 32'(k) * 32'h11);
                chk("t2_st_size", {30'h0, log_size[k]}, 32'h0);
                chk("t2_st_cyc", log_cyc[k], log_cyc[0] + k);
            end
        end
        do_req(1'b0, 32'h21, 32'h0, 2'b10, 1'b1);
        chk("t2_ld_lat", r_lat, 5);
        chk("t2_ld_data", r_data, 32'h11223344);
        chk("t2_ld_nops", log_addr.size(), 4);
        // aligned half over bytes 0x33,0x22 at 0x22..0x23 -> 0x2233, positive
        do_req(1'b0, 32'h22, 32'h0, 2'b01, 1'b0);
        chk("t2_half_lat", r_lat, 2);
        chk("t2_half_data", r_data, 32'h00002233);
`endif

        // 3: misaligned half load, sign and zero extension
`ifdef MISALIGN_TRAP_EN
        clear_log();
        do_req(1'b0, 32'h33, 32'h0, 2'b01, 1'b0);
        chk("t3_ld_err", {31'h0, r_err}, 32'h1);
        chk("t3_ld_data", r_data, 32'h0);
        chk("t3_ld_lat", r_lat, 1);
`else
        do_req(1'b1, 32'h33, 32'h0000FF80, 2'b01, 1'b0);
        chk("t3_st_lat", r_lat, 3);
        do_req(1'b0, 32'h33, 32'h0, 2'b01, 1'b0);
        chk("t3_ld_sext", r_data, 32'hFFFFFF80);
        chk("t3_ld_lat", r_lat, 3);
        do_req(1'b0, 32'h33, 32'h0, 2'b01, 1'b1);
        chk("t3_ld_zext", r_data, 32'h0000FF80);
        do_req(1'b0, 32'h33, 32'h0, 2'b00, 1'b0);
        chk("t3_byte_sext", r_data, 32'hFFFFFF80);
        do_req(1'b0, 32'h34, 32'h0, 2'b00, 1'b1);
        chk("t3_byte_zext", r_data, 32'h000000FF);
`endif

        // 4: word store across the top of the address space
        clear_log();
        do_req(1'b1, 32'hFFFFFFFE, 32'hCAFEF00D, 2'b10, 1'b0);
`ifdef MISALIGN_TRAP_EN
        chk("t4_st_err", {31'h0, r_err}, 32'h1);
        chk("t4_st_nops", log_addr.size(), 0);
`else
        chk("t4_st_nops", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            chk("t4_addr0", log_addr[0], 32'hFFFFFFFE);
            chk("t4_addr1", log_addr[1], 32'hFFFFFFFF);
            chk("t4_addr2", log_addr[2], 32'h00000000);
            chk("t4_addr3", log_addr[3], 32'h00000001);
            chk("t4_byte0", log_data[0], 32'h0D);
            chk("t4_byte3", log_data[3], 32'hCA);
        end
        do_req(1'b0, 32'hFFFFFFFE, 32'h0, 2'b10, 1'b0);
        chk("t4_ld_data", r_data, 32'hCAFEF00D);
`endif

        // 5: illegal size, response held under backpressure
        clear_log();
        start_req(1'b1, 32'h40, 32'h12345678, 2'b11, 1'b0, 1'b0);
        chk("t5_lat", r_lat, 1);
        chk("t5_err", {31'h0, r_err}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("t5_hold_valid", {31'h0, resp_valid}, 32'h1);
            chk("t5_hold_err", {31'h0, resp_error}, 32'h1);
            chk("t5_hold_data", resp_read_data, 32'h0);
        end
        finish_resp();
        chk("t5_idle_valid", {31'h0, resp_valid}, 32'h0);
        chk("t5_nops", log_addr.size(), 0);
        do_req(1'b0, 32'h10, 32'h0, 2'b11, 1'b0);
        chk("t5_ld_err", {31'h0, r_err}, 32'h1);
        chk("t5_ld_data", r_data, 32'h0);

        // 6: reset during the second byte op of a misaligned store
        clear_log();
        @(negedge clk);
        req_write      = 1'b1;
        req_address    = 32'h41;
        req_write_data = 32'hAABBCCDD;
        req_data_size  = 2'b10;
        req_valid      = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_req_ready", {31'h0, req_ready}, 32'h1);
        chk("t6_we", {31'h0, mem_write_enable}, 32'h0);
        chk("t6_resp_valid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
`ifdef MISALIGN_TRAP_EN
        chk("t6_nops", log_addr.size(), 0);
`else
        chk("t6_nops", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            chk("t6_addr", log_addr[0], 32'h41);
            chk("t6_byte", log_data[0], 32'hDD);
        end
`endif
        chk("t6_idle_ready", {31'h0, req_ready}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
